// File: rtl/cache_control.sv
// Miss/hit sequencer for a 2-way set-associative write-back L1 cache.
// Compares tags, steers way/LRU loads, picks the victim, and runs the
// WRITEBACK/ALLOCATE handshake with physical memory over 128-bit lines.
module cache_control #(
    parameter int TAG_W = 9,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    output logic             mem_resp,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             lru,
    output logic [1:0]       way_load,
    output logic             data_src,
    output logic             dirty_in,
    output logic             lru_load,
    output logic             lru_in,
    output logic             rdata_way,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [15:0]      pmem_address,
    input  logic             pmem_resp
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             victim_q, victim_d;

    logic [TAG_W-1:0] addr_tag;
    logic [IDX_W-1:0] addr_idx;
    logic             hit0, hit1, hit, hit_way;
    logic             req;
    logic             victim, victim_dirty;
    logic [TAG_W-1:0] wb_tag;

    assign addr_tag = mem_address[15 -: TAG_W];
    assign addr_idx = mem_address[4 +: IDX_W];

    assign hit0    = valid0 && (tag0 == addr_tag);
    assign hit1    = valid1 && (tag1 == addr_tag);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;              // way 0 wins when both match
    assign req     = mem_read || mem_write;

    // Invalid ways are filled first; only a fully valid set consults LRU.
    assign victim       = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);
    assign victim_dirty = victim ? (valid1 && dirty1) : (valid0 && dirty0);
    assign wb_tag       = victim_q ? tag1 : tag0;

    // State and latched victim way.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Next-state and outputs; everything is held at 0 while reset is high.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        way_load     = 2'b00;
        data_src     = 1'b0;
        dirty_in     = 1'b0;
        lru_load     = 1'b0;
        lru_in       = 1'b0;
        rdata_way    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp  = 1'b1;
                        rdata_way = hit_way;
                        lru_load  = 1'b1;
                        lru_in    = ~hit_way;
                        if (mem_write) begin
                            way_load[hit_way] = 1'b1;
                            dirty_in          = 1'b1;
                        end
                    end else if (req) begin
                        victim_d = victim;
                        state_d  = victim_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    rdata_way    = victim_q;
                    pmem_address = {wb_tag, addr_idx, 4'h0};
                    if (pmem_resp) state_d = ALLOCATE;
                end
                ALLOCATE: begin
                    pmem_read    = 1'b1;
                    pmem_address = {mem_address[15:4], 4'h0};
                    if (pmem_resp) begin
                        way_load[victim_q] = 1'b1;
                        data_src           = 1'b1;
                        state_d            = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_control.sv
// Bench for cache_control: reset/IDLE vector table, hand-written miss
// sequences, and random traffic against a transaction-level cache model.
module tb_cache_control;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_read, mem_write, mem_resp, pmem_resp;
    logic [15:0] mem_address, pmem_address;
    logic [8:0]  tag0, tag1;
    logic        valid0, valid1, dirty0, dirty1, lru;
    logic [1:0]  way_load;
    logic        data_src, dirty_in, lru_load, lru_in, rdata_way, pmem_read, pmem_write;

    cache_control dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_resp(mem_resp),
        .tag0(tag0), .tag1(tag1), .valid0(valid0), .valid1(valid1),
        .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
        .way_load(way_load), .data_src(data_src), .dirty_in(dirty_in),
        .lru_load(lru_load), .lru_in(lru_in), .rdata_way(rdata_way),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_resp(pmem_resp)
    );

    // Bench-side cache arrays, written from the DUT's load strobes.
    logic [8:0] dt [8][2];
    logic [1:0] dv [8];
    logic [1:0] dd [8];
    logic       dl [8];
    logic [2:0] cidx;
    assign cidx = mem_address[6:4];

    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 8; s++) begin
                dv[s] <= 2'b00; dd[s] <= 2'b00; dl[s] <= 1'b0;
                dt[s][0] <= 9'h0; dt[s][1] <= 9'h0;
            end
        end else begin
            for (int w = 0; w < 2; w++)
                if (way_load[w]) begin
                    dt[cidx][w] <= mem_address[15:7];
                    dv[cidx][w] <= 1'b1;
                    dd[cidx][w] <= dirty_in;
                end
            if (lru_load) dl[cidx] <= lru_in;
        end
    end

    // Array inputs come either from the bench arrays or from fixed overrides.
    logic       use_dp;
    logic [8:0] o_t0, o_t1;
    logic       o_v0, o_v1, o_d0, o_d1, o_l;
    assign tag0   = use_dp ? dt[cidx][0] : o_t0;
    assign tag1   = use_dp ? dt[cidx][1] : o_t1;
    assign valid0 = use_dp ? dv[cidx][0] : o_v0;
    assign valid1 = use_dp ? dv[cidx][1] : o_v1;
    assign dirty0 = use_dp ? dd[cidx][0] : o_d0;
    assign dirty1 = use_dp ? dd[cidx][1] : o_d1;
    assign lru    = use_dp ? dl[cidx]    : o_l;

    logic [31:0] obs;
    assign obs = {6'b0, mem_resp, way_load, data_src, dirty_in, lru_load, lru_in,
                  rdata_way, pmem_read, pmem_write, pmem_address};

    function automatic logic [31:0] mk(input logic resp, input logic [1:0] wl,
        input logic ds, input logic di, input logic ll, input logic li,
        input logic rw, input logic pr, input logic pw, input logic [15:0] pa);
        return {6'b0, resp, wl, ds, di, ll, li, rw, pr, pw, pa};
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic set_ovr(input logic [8:0] t0, input logic [8:0] t1, input logic v0,
                           input logic v1, input logic d0, input logic d1, input logic l);
        o_t0 = t0; o_t1 = t1; o_v0 = v0; o_v1 = v1; o_d0 = d0; o_d1 = d1; o_l = l;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [15:0] addr;
        logic [8:0]  t0, t1;
        logic        v0, v1, d0, d1, l;
        logic [31:0] exp;
    } vec_t;
    vec_t vec [9];

    // Transaction-level reference cache.
    logic [8:0] mt [8][2];
    logic [1:0] mv [8];
    logic [1:0] md [8];
    logic       ml [8];

    initial begin
        logic [8:0]  tg;
        logic [2:0]  ix;
        logic [15:0] addr, wbaddr, rdaddr;
        logic        wr, h0, h1, miss, way, vict, wb, done;
        logic [1:0]  oh;
        int          cyc, wcnt, rcnt, lw, lr, op, exp_cyc;

        //            rd    wr    addr      tag0    tag1    v0    v1    d0    d1    lru
        vec[0] = '{1'b1, 1'b0, 16'h1234, 9'h024, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                   mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0)};
        vec[1] = '{1'b0, 1'b1, 16'h1236, 9'h024, 9'h024, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                   mk(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0)};
        vec[2] = '{1'b1, 1'b0, 16'h1234, 9'h024, 9'h024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                   mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0)};
        vec[3] = '{1'b1, 1'b1, 16'h1234, 9'h024, 9'h024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                   mk(1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0)};
        vec[4] = '{1'b1, 1'b0, 16'h1234, 9'h024, 9'h024, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   32'h0};
        vec[5] = '{1'b0, 1'b0, 16'h1234, 9'h024, 9'h024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                   32'h0};
        vec[6] = '{1'b1, 1'b0, 16'h1234, 9'h025, 9'h023, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                   32'h0};
        vec[7] = '{1'b0, 1'b1, 16'hFFF0, 9'h000, 9'h1FF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                   mk(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0)};
        vec[8] = '{1'b1, 1'b0, 16'h0008, 9'h000, 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                   mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0)};

        use_dp = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 16'h0;
        set_ovr(9'h024, 9'h024, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Outputs forced low while reset is high, even on a write hit.
        reset = 1'b1; mem_write = 1'b1; mem_address = 16'h1234;
        @(negedge clk);
        check("reset_outputs", obs, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_ovr(vec[i].t0, vec[i].t1, vec[i].v0, vec[i].v1, vec[i].d0, vec[i].d1, vec[i].l);
            mem_read = vec[i].rd; mem_write = vec[i].wr; mem_address = vec[i].addr;
            @(negedge clk);
            check($sformatf("vec%0d", i), obs, vec[i].exp);
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
        end

        // Cold read miss fills way 0, then hits.
        use_dp = 1'b1;
        do_reset();
        mem_read = 1'b1; mem_address = 16'h1234;
        @(negedge clk); check("t1_miss", obs, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); check("t1_alloc", obs, mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 16'h1230));
        pmem_resp = 1'b1; #1;
        check("t1_fill", obs, mk(0, 2'b01, 1, 0, 0, 0, 0, 1, 0, 16'h1230));
        @(posedge clk); #1; pmem_resp = 1'b0;
        @(negedge clk); check("t1_hit", obs, mk(1, 2'b00, 0, 0, 1, 1, 0, 0, 0, 16'h0));
        @(posedge clk); #1; mem_read = 1'b0;

        // Dirty victim in way 1: writeback held 6 cycles, then allocate.
        use_dp = 1'b0;
        do_reset();
        set_ovr(9'h011, 9'h0AB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        mem_read = 1'b1; mem_address = 16'h1234;
        @(negedge clk); check("t3_miss", obs, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("t4_wb%0d", k), obs, mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 16'h55B0));
            if (k == 5) pmem_resp = 1'b1;
            @(posedge clk); #1; pmem_resp = 1'b0;
        end
        @(negedge clk); check("t3_alloc", obs, mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 16'h1230));
        pmem_resp = 1'b1; #1;
        check("t3_fill", obs, mk(0, 2'b10, 1, 0, 0, 0, 0, 1, 0, 16'h1230));
        @(posedge clk); #1; pmem_resp = 1'b0; mem_read = 1'b0;

        // Reset in the second ALLOCATE cycle.
        do_reset();
        set_ovr(9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mem_read = 1'b1; mem_address = 16'h1234;
        @(posedge clk); #1;
        @(negedge clk); check("t5_alloc1", obs, mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 16'h1230));
        @(posedge clk); #1; reset = 1'b1; pmem_resp = 1'b1;
        @(negedge clk); check("t5_reset", obs, 32'h0);
        @(posedge clk); #1; reset = 1'b0; pmem_resp = 1'b0;
        @(negedge clk); check("t5_idle", obs, 32'h0);
        @(posedge clk); #1; mem_read = 1'b0;

        // Invalid way 1 is the victim: no writeback.
        do_reset();
        set_ovr(9'h011, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        mem_read = 1'b1; mem_address = 16'h1234;
        @(negedge clk); check("t6_miss", obs, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); check("t6_alloc", obs, mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 16'h1230));
        pmem_resp = 1'b1; #1;
        check("t6_fill", obs, mk(0, 2'b10, 1, 0, 0, 0, 0, 1, 0, 16'h1230));
        @(posedge clk); #1; pmem_resp = 1'b0; mem_read = 1'b0;

        // Random traffic against the reference cache.
        use_dp = 1'b1;
        do_reset();
        for (int s = 0; s < 8; s++) begin
            mv[s] = 2'b00; md[s] = 2'b00; ml[s] = 1'b0; mt[s][0] = 9'h0; mt[s][1] = 9'h0;
        end
        for (int t = 0; t < 150; t++) begin
            tg   = 9'h010 + 9'($urandom_range(0, 2));
            ix   = 3'($urandom_range(0, 1));
            addr = {tg, ix, 4'($urandom_range(0, 15))};
            op   = int'($urandom_range(0, 2));
            wr   = (op != 0);
            lw   = int'($urandom_range(0, 3));
            lr   = int'($urandom_range(0, 3));
            h0   = mv[ix][0] && (mt[ix][0] == tg);
            h1   = mv[ix][1] && (mt[ix][1] == tg);
            miss = !(h0 || h1);
            vict = !mv[ix][0] ? 1'b0 : (!mv[ix][1] ? 1'b1 : ml[ix]);
            wb   = miss && mv[ix][vict] && md[ix][vict];
            wbaddr = {mt[ix][vict], ix, 4'h0};
            rdaddr = {addr[15:4], 4'h0};
            if (miss) begin
                way = vict;
                mt[ix][vict] = tg; mv[ix][vict] = 1'b1; md[ix][vict] = 1'b0;
            end else begin
                way = h0 ? 1'b0 : 1'b1;
            end
            ml[ix] = ~way;
            if (wr) md[ix][way] = 1'b1;
            oh = vict ? 2'b10 : 2'b01;
            exp_cyc = miss ? (1 + (wb ? lw + 1 : 0) + lr + 1 + 1) : 1;

            mem_read = (op != 1); mem_write = wr; mem_address = addr;
            cyc = 0; wcnt = 0; rcnt = 0; done = 1'b0;
            while (!done && cyc < 64) begin
                @(negedge clk); pmem_resp = 1'b0; #1; cyc++;
                if (mem_resp) begin
                    done = 1'b1;
                    check("rnd_resp", obs, mk(1, wr ? (way ? 2'b10 : 2'b01) : 2'b00,
                                              0, wr, 1, ~way, way, 0, 0, 16'h0));
                end else if (pmem_write) begin
                    if (wcnt == 0) check("rnd_wb", obs, mk(0, 2'b00, 0, 0, 0, 0, vict, 0, 1, wbaddr));
                    if (wcnt == lw) pmem_resp = 1'b1;
                    wcnt++;
                end else if (pmem_read) begin
                    if (rcnt == lr) begin
                        pmem_resp = 1'b1; #1;
                        check("rnd_fill", obs, mk(0, oh, 1, 0, 0, 0, 0, 1, 0, rdaddr));
                    end else if (rcnt == 0) begin
                        check("rnd_alloc", obs, mk(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, rdaddr));
                    end
                    rcnt++;
                end
            end
            check("rnd_done", 32'(done), 32'h1);
            check("rnd_latency", 32'(cyc), 32'(exp_cyc));
            check("rnd_wb_seen", 32'(wcnt != 0), 32'(wb));
            @(posedge clk); #1;
            check("rnd_arrays", {9'b0, dt[ix][1], dt[ix][0], dv[ix], dd[ix], dl[ix]},
                                {9'b0, mt[ix][1], mt[ix][0], mv[ix], md[ix], ml[ix]});
            // Idle gap; a stray pmem_resp here must be ignored.
            mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'($urandom_range(0, 1));
            @(negedge clk); check("rnd_idle", obs, 32'h0);
            @(posedge clk); #1; pmem_resp = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
